// File: rtl/core_hazard_ctrl.sv
// core_hazard_ctrl: pipe-register enable/clear and PC-hold control for the 5-stage core.
// Optional perf counters are built when CORE_HAZARD_PERF_EN is defined.
`default_nettype none

module core_hazard_ctrl #(
  parameter int W_REG       = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int W_CNT       = 32
) (
  input  logic             i_pipe_clk,
  input  logic             i_pipe_rst_n,
  input  logic [W_REG-1:0] i_id_rs1,
  input  logic [W_REG-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [W_REG-1:0] i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_gnt,
  output logic             o_bus_req,
  output logic             o_mem_err,
  output logic             o_pc_en_n,
  output logic             o_ifid_en_n,
  output logic             o_idex_en_n,
  output logic             o_exmem_en_n,
  output logic             o_memwb_en_n,
  output logic             o_ifid_clr,
  output logic             o_idex_clr,
  output logic             o_exmem_clr,
  output logic             o_memwb_clr,
  output logic [W_CNT-1:0] o_stall_cnt,
  output logic [W_CNT-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } mstate_e;

  localparam int W_TO = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W_TO-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? W_TO'(MEM_TIMEOUT - 1) : '0;

  mstate_e         state_q, state_d;
  logic [W_TO-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            timeout, mem_stall, load_use;

  // A grant on the last permitted cycle takes precedence over the timeout.
  assign timeout   = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_LAST) && !i_mem_gnt;
  assign mem_stall = ((state_q == M_IDLE) && i_mem_req) || (state_q == M_WAIT);
  assign load_use  = i_ex_mem_read && (i_ex_rd != '0) &&
                     ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                      (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n) begin
    if (!i_pipe_rst_n) begin
      state_q  <= M_IDLE;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (i_mem_req) begin
          state_d  = M_WAIT;
          to_cnt_d = '0;
        end
      end
      M_WAIT: begin
        if (i_mem_gnt) begin
          state_d = M_DONE;
        end else if (timeout) begin
          state_d = M_DONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      M_DONE:  state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  assign o_bus_req = (state_q == M_WAIT);
  assign o_mem_err = err_q;

  always_comb begin
    o_pc_en_n    = 1'b0;
    o_ifid_en_n  = 1'b0;
    o_idex_en_n  = 1'b0;
    o_exmem_en_n = 1'b0;
    o_memwb_en_n = 1'b0;
    o_ifid_clr   = 1'b0;
    o_idex_clr   = 1'b0;
    o_exmem_clr  = 1'b0;
    o_memwb_clr  = 1'b0;
    if (!i_pipe_rst_n) begin
      o_pc_en_n    = 1'b1;
      o_ifid_en_n  = 1'b1;
      o_idex_en_n  = 1'b1;
      o_exmem_en_n = 1'b1;
      o_memwb_en_n = 1'b1;
    end else if (mem_stall) begin
      // The redirecting instruction stays held in EX until the stall clears.
      o_pc_en_n    = 1'b1;
      o_ifid_en_n  = 1'b1;
      o_idex_en_n  = 1'b1;
      o_exmem_en_n = 1'b1;
      o_memwb_clr  = 1'b1;
    end else if (i_ex_redirect) begin
      o_ifid_clr = 1'b1;
      o_idex_clr = 1'b1;
    end else if (load_use) begin
      o_pc_en_n   = 1'b1;
      o_ifid_en_n = 1'b1;
      o_idex_clr  = 1'b1;
    end
  end

`ifdef CORE_HAZARD_PERF_EN
  logic [W_CNT-1:0] stall_cnt_q, stall_cnt_d;
  logic [W_CNT-1:0] flush_cnt_q, flush_cnt_d;

  // ifid_clr is raised only by a redirect that takes effect.
  assign stall_cnt_d = (o_pc_en_n  && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (o_ifid_clr && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n) begin
    if (!i_pipe_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_hazard_ctrl.sv
// tb_core_hazard_ctrl: directed + random checks of core_hazard_ctrl against a transaction-level model.
`default_nettype none

module tb_core_hazard_ctrl;
  localparam int MEM_TO = 4;
  localparam int WC     = 4;
  localparam int CMAX   = (1 << WC) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 0, u2 = 0, mrd = 0, redir = 0, req = 0, gnt = 0;

  logic bus_req, mem_err, pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic [WC-1:0] stall_cnt, flush_cnt;

  core_hazard_ctrl #(.W_REG(5), .MEM_TIMEOUT(MEM_TO), .W_CNT(WC)) dut (
    .i_pipe_clk(clk), .i_pipe_rst_n(rst_n),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(u1), .i_id_use_rs2(u2),
    .i_ex_rd(rd), .i_ex_mem_read(mrd), .i_ex_redirect(redir),
    .i_mem_req(req), .i_mem_gnt(gnt),
    .o_bus_req(bus_req), .o_mem_err(mem_err), .o_pc_en_n(pc_en_n),
    .o_ifid_en_n(ifid_en_n), .o_idex_en_n(idex_en_n), .o_exmem_en_n(exmem_en_n),
    .o_memwb_en_n(memwb_en_n), .o_ifid_clr(ifid_clr), .o_idex_clr(idex_clr),
    .o_exmem_clr(exmem_clr), .o_memwb_clr(memwb_clr),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {bus_req, mem_err, pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n,
                ifid_clr, idex_clr, exmem_clr, memwb_clr};

  int total = 0, bad = 0, bus_hi = 0;

  // Model: a memory transaction is either waiting (m_busy, m_waits cycles so far)
  // or in its one retire cycle (m_done), plus the perf tallies.
  bit m_busy, m_done, m_err;
  int m_waits, m_sc, m_fc;

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_waits = 0; m_sc = 0; m_fc = 0;
  endfunction

  function automatic bit lu_now();
    return mrd && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  function automatic bit stall_now();
    return m_busy || (!m_done && req);
  endfunction

  function automatic logic [10:0] model_out();
    logic [1:0] hd;
    if (!rst_n) return 11'b00_11111_0000;
    hd = {m_busy, m_err};
    if (stall_now())  return {hd, 5'b11110, 4'b0001};
    if (redir)        return {hd, 5'b00000, 4'b1100};
    if (lu_now())     return {hd, 5'b11000, 4'b0100};
    return {hd, 9'b0};
  endfunction

  function automatic void model_step();
    bit st, hold, fl;
    st   = stall_now();
    hold = st || (!redir && lu_now());
    fl   = !st && redir;
    if (hold && m_sc < CMAX) m_sc++;
    if (fl && m_fc < CMAX) m_fc++;
    if (m_done) begin
      m_done = 0; m_err = 0;
    end else if (m_busy) begin
      m_waits++;
      if (gnt) begin
        m_busy = 0; m_done = 1;
      end else if (m_waits == MEM_TO) begin
        m_busy = 0; m_done = 1; m_err = 1;
      end
    end else if (req) begin
      m_busy = 1; m_waits = 0;
    end
  endfunction

  task automatic drive(input bit rq, input bit gt, input bit rdr, input bit ld,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input bit a1, input bit a2);
    req = rq; gnt = gt; redir = rdr; mrd = ld; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2;
  endtask

  task automatic tick(input string tag);
    logic [10:0] e;
    logic [WC-1:0] es, ef;
    if (!rst_n) model_reset();
    @(negedge clk);
    e = model_out();
`ifdef CORE_HAZARD_PERF_EN
    es = WC'(m_sc); ef = WC'(m_fc);
`else
    es = '0; ef = '0;
`endif
    if (bus_req === 1'b1) bus_hi++;
    total++;
    assert (obs === e) else begin
      bad++; $error("FAIL %s ctl obs=%b exp=%b", tag, obs, e);
    end
    total++;
    assert ({stall_cnt, flush_cnt} === {es, ef}) else begin
      bad++; $error("FAIL %s cnt obs=%0d/%0d exp=%0d/%0d", tag, stall_cnt, flush_cnt, es, ef);
    end
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  initial begin
    model_reset();
    // Reset state
    tick("reset0");
    tick("reset1");
    rst_n = 1'b1;
    tick("run_idle");

    // Load-use hit, then rd = x0 (no stall)
    drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 1); tick("lu_hit");
    drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd1, 1, 1); tick("lu_x0");
    drive(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1); tick("lu_rs2");
    drive(0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0, 1); tick("lu_unused");

    // Memory stall, grant on the third WAIT cycle
    bus_hi = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("mem_idle_req");
    tick("mem_wait1");
    tick("mem_wait2");
    gnt = 1; tick("mem_wait3_gnt");
    gnt = 0; tick("mem_done");
    req = 0; tick("mem_after");
    total++;
    assert (bus_hi === 3) else begin
      bad++; $error("FAIL bus_req_len obs=%0d exp=3", bus_hi);
    end

    // Redirect squashes load-use; redirect during a stall lands in the DONE cycle
    drive(0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 0); tick("redir_lu");
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick("redir_stall_idle");
    tick("redir_stall_wait");
    gnt = 1; tick("redir_stall_gnt");
    gnt = 0; tick("redir_done");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("redir_after");

    // Timeout with no grant, then a grant on the final allowed cycle
    req = 1; tick("to_idle");
    for (int i = 0; i < MEM_TO; i++) tick("to_wait");
    tick("to_done_err");
    req = 0; tick("to_after");
    req = 1; tick("to2_idle");
    for (int i = 0; i < MEM_TO - 1; i++) tick("to2_wait");
    gnt = 1; tick("to2_last_gnt");
    gnt = 0; tick("to2_done_noerr");
    req = 0; tick("to2_after");

    // Asynchronous reset in the middle of WAIT
    req = 1; tick("rst_idle");
    tick("rst_wait");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    assert (obs === 11'b00_11111_0000) else begin
      bad++; $error("FAIL async_rst obs=%b exp=%b", obs, 11'b00_11111_0000);
    end
    tick("rst_low");
    req = 0; rst_n = 1'b1;
    tick("rst_release");

    // 20 load-use cycles drive the stall counter into saturation
    drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    for (int i = 0; i < 20; i++) tick("perf_lu");
    total++;
`ifdef CORE_HAZARD_PERF_EN
    assert (stall_cnt === 4'd15) else begin
      bad++; $error("FAIL stall_sat obs=%0d exp=15", stall_cnt);
    end
`else
    assert (stall_cnt === 4'd0) else begin
      bad++; $error("FAIL stall_off obs=%0d exp=0", stall_cnt);
    end
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(2) == 0), ($urandom_range(5) == 0),
            ($urandom_range(1) == 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
            5'($urandom_range(3)), ($urandom_range(1) == 0), ($urandom_range(1) == 0));
      rst_n = ($urandom_range(99) != 0);
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
